cam_dvp_capture: RTL and testbench

- Parametrised camera pixel front end running in the camera pixel clock domain.
- Samples the raw DVP byte stream (vsync, href, 8-bit data) from the OV-style sensor and tracks frame and line framing.
- Assembles byte pairs into pixels, converts one of four runtime-selected formats to RGB888 and emits pixels with x/y coordinates and frame markers.
- Sits between the camera pins and the frame buffer / display pipeline.

---
 rtl/cam_dvp_capture.sv | 232 +++++++++++++++++++++++
 tb/tb_cam_dvp_capture.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_dvp_capture.sv
`default_nettype none
// ============================================================================
// Module   : cam_dvp_capture
// Purpose  : DVP camera front end in the pixel clock domain. Registers the raw
//            vsync/href/data stream, tracks frame and line framing, pairs
//            bytes into pixels, converts RGB565 / RGB444 / RGB555 / YUYV-luma
//            to RGB888 and emits pixels with coordinates and frame markers.
// Ports    : clk_pixel, rst_n              clock, async active-low reset
//            cam_vsync, cam_href, cam_data raw sensor interface
//            capture_en, mode              frame controls, latched at frame start
//            pix_valid, pix_red/green/blue RGB888 pixel strobe and data
//            pix_x, pix_y, sof, eol, eof   coordinates and framing pulses
//            frame_err, frame_cnt          sticky framing error, frame counter
// Revision : 1.0 - initial release
// ============================================================================
module cam_dvp_capture #(
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int BYTE_SWAP = 0,
  parameter int FCNT_W    = 16
) (
  input  logic                      clk_pixel,
  input  logic                      rst_n,
  input  logic                      cam_vsync,
  input  logic                      cam_href,
  input  logic [7:0]                cam_data,
  input  logic                      capture_en,
  input  logic [1:0]                mode,
  output logic                      pix_valid,
  output logic [7:0]                pix_red,
  output logic [7:0]                pix_green,
  output logic [7:0]                pix_blue,
  output logic [$clog2(H_RES)-1:0]  pix_x,
  output logic [$clog2(V_RES)-1:0]  pix_y,
  output logic                      sof,
  output logic                      eol,
  output logic                      eof,
  output logic                      frame_err,
  output logic [FCNT_W-1:0]         frame_cnt
);

  localparam int XW  = $clog2(H_RES);
  localparam int YW  = $clog2(V_RES);
  // Internal counters need one extra value so that "H_RES pixels seen" and
  // "V_RES lines seen" are representable for the end-of-line/frame checks.
  localparam int XCW = $clog2(H_RES + 1);
  localparam int YCW = $clog2(V_RES + 1);

  localparam logic [XCW-1:0] c_x_end  = XCW'(H_RES);
  localparam logic [XCW-1:0] c_x_last = XCW'(H_RES - 1);
  localparam logic [YCW-1:0] c_y_end  = YCW'(V_RES);

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    BLANK   = 2'd1,
    SKIP    = 2'd2,
    ACTIVE  = 2'd3
  } state_t;

  state_t r_state, w_next;

  logic           r_vs, r_hr, r_vs_d, r_hr_d;
  logic [7:0]     r_data, r_b0;
  logic [1:0]     r_mode;
  logic           r_phase, r_line_got;
  logic [XCW-1:0] r_x;
  logic [YCW-1:0] r_y;

  logic           w_vs_rise, w_vs_fall, w_line_end, w_byte, w_emit;
  logic           w_line_err;
  logic [YCW-1:0] w_y_after, w_y_final;
  logic [7:0]     w_p0, w_p1, w_r, w_g, w_b;
  logic [5:0]     w_g6;
  logic [4:0]     w_g5;

  // Input stage and one-cycle-delayed copies for edge detection.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      r_vs   <= 1'b0;
      r_hr   <= 1'b0;
      r_data <= 8'd0;
      r_vs_d <= 1'b0;
      r_hr_d <= 1'b0;
    end else begin
      r_vs   <= cam_vsync;
      r_hr   <= cam_href;
      r_data <= cam_data;
      r_vs_d <= r_vs;
      r_hr_d <= r_hr;
    end
  end

  assign w_vs_rise = r_vs & ~r_vs_d;
  assign w_vs_fall = ~r_vs & r_vs_d;
  // A vsync rise while href is still high closes the open line in the same
  // cycle, so line checks happen before the frame check.
  assign w_line_end = (r_state == ACTIVE) & r_hr_d & (~r_hr | w_vs_rise);
  assign w_byte     = (r_state == ACTIVE) & r_hr & ~w_vs_rise;
  assign w_emit     = w_byte & r_phase & (r_x < c_x_end) & (r_y < c_y_end);

  // y saturates at V_RES; any further line with data is an overflow.
  assign w_y_after  = (r_line_got && (r_y < c_y_end)) ? r_y + YCW'(1) : r_y;
  assign w_line_err = r_phase | (r_x != c_x_end) | (r_line_got & (r_y >= c_y_end));
  assign w_y_final  = w_line_end ? w_y_after : r_y;

  // Format decode with MSB replication to 8 bits.
  always_comb begin
    w_p0 = (BYTE_SWAP != 0) ? r_data : r_b0;
    w_p1 = (BYTE_SWAP != 0) ? r_b0   : r_data;
    w_g6 = {w_p0[2:0], w_p1[7:5]};
    w_g5 = {w_p0[1:0], w_p1[7:5]};
    w_r  = 8'd0;
    w_g  = 8'd0;
    w_b  = 8'd0;
    case (r_mode)
      2'd0: begin
        w_r = {w_p0[7:3], w_p0[7:5]};
        w_g = {w_g6, w_g6[5:4]};
        w_b = {w_p1[4:0], w_p1[4:2]};
      end
      2'd1: begin
        w_r = {w_p0[3:0], w_p0[3:0]};
        w_g = {w_p1[7:4], w_p1[7:4]};
        w_b = {w_p1[3:0], w_p1[3:0]};
      end
      2'd2: begin
        w_r = {w_p0[6:2], w_p0[6:4]};
        w_g = {w_g5, w_g5[4:2]};
        w_b = {w_p1[4:0], w_p1[4:2]};
      end
      default: begin
        w_r = w_p0;
        w_g = w_p0;
        w_b = w_p0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) r_state <= WAIT_VS;
    else        r_state <= w_next;
  end

  // Next-state logic. WAIT_VS refuses to join a frame already in progress.
  always_comb begin
    w_next = r_state;
    case (r_state)
      WAIT_VS: if (r_vs)      w_next = BLANK;
      BLANK:   if (w_vs_fall) w_next = capture_en ? ACTIVE : SKIP;
      SKIP:    if (w_vs_rise) w_next = BLANK;
      ACTIVE:  if (w_vs_rise) w_next = BLANK;
      default:                w_next = WAIT_VS;
    endcase
  end

  // Datapath: byte pairing, coordinates, framing checks and outputs.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      r_mode     <= 2'd0;
      r_b0       <= 8'd0;
      r_phase    <= 1'b0;
      r_line_got <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      pix_valid  <= 1'b0;
      pix_red    <= 8'd0;
      pix_green  <= 8'd0;
      pix_blue   <= 8'd0;
      pix_x      <= '0;
      pix_y      <= '0;
      sof        <= 1'b0;
      eol        <= 1'b0;
      eof        <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      pix_valid <= 1'b0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      eof       <= 1'b0;

      if ((r_state == BLANK) && w_vs_fall) begin
        r_mode     <= mode;
        frame_err  <= 1'b0;
        r_x        <= '0;
        r_y        <= '0;
        r_phase    <= 1'b0;
        r_line_got <= 1'b0;
      end

      if (w_byte) begin
        if (!r_phase) begin
          r_b0       <= r_data;
          r_phase    <= 1'b1;
          r_line_got <= 1'b1;
        end else begin
          r_phase <= 1'b0;
          if (w_emit) begin
            pix_valid <= 1'b1;
            pix_red   <= w_r;
            pix_green <= w_g;
            pix_blue  <= w_b;
            pix_x     <= r_x[XW-1:0];
            pix_y     <= r_y[YW-1:0];
            sof       <= (r_x == '0) && (r_y == '0);
            eol       <= (r_x == c_x_last);
            r_x       <= r_x + XCW'(1);
          end else begin
            frame_err <= 1'b1;
          end
        end
      end

      if (w_line_end) begin
        if (w_line_err) frame_err <= 1'b1;
        r_x        <= '0;
        r_phase    <= 1'b0;
        r_line_got <= 1'b0;
        r_y        <= w_y_after;
      end

      if ((r_state == ACTIVE) && w_vs_rise) begin
        eof       <= 1'b1;
        frame_cnt <= frame_cnt + FCNT_W'(1);
        if (w_y_final != c_y_end) frame_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cam_dvp_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_dvp_capture
// Purpose  : Directed self-checking bench for cam_dvp_capture. Two instances
//            share one camera stream: dut0 (no swap, 16-bit frame counter)
//            and dut1 (byte swap, 2-bit frame counter), both 4x2 resolution.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cam_dvp_capture;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [1:0] x;
    logic       y;
    logic       sof;
    logic       eol;
  } pix_t;

  logic        clk_pixel, rst_n, cam_vsync, cam_href, capture_en;
  logic [7:0]  cam_data;
  logic [1:0]  mode;

  logic        v0, sof0, eol0, eof0, err0;
  logic [7:0]  r0, g0, b0;
  logic [1:0]  x0;
  logic        y0;
  logic [15:0] cnt0;

  logic        v1, sof1, eol1, eof1, err1;
  logic [7:0]  r1, g1, b1;
  logic [1:0]  x1;
  logic        y1;
  logic [1:0]  cnt1;

  cam_dvp_capture #(.H_RES(4), .V_RES(2), .BYTE_SWAP(0), .FCNT_W(16)) dut0 (
    .clk_pixel(clk_pixel), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .capture_en(capture_en), .mode(mode), .pix_valid(v0),
    .pix_red(r0), .pix_green(g0), .pix_blue(b0), .pix_x(x0), .pix_y(y0),
    .sof(sof0), .eol(eol0), .eof(eof0), .frame_err(err0), .frame_cnt(cnt0));

  cam_dvp_capture #(.H_RES(4), .V_RES(2), .BYTE_SWAP(1), .FCNT_W(2)) dut1 (
    .clk_pixel(clk_pixel), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .capture_en(capture_en), .mode(mode), .pix_valid(v1),
    .pix_red(r1), .pix_green(g1), .pix_blue(b1), .pix_x(x1), .pix_y(y1),
    .sof(sof1), .eol(eol1), .eof(eof1), .frame_err(err1), .frame_cnt(cnt1));

  initial clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  pix_t q0[$];
  pix_t q1[$];
  int   n_eof0, n_eof1, first0, first1, t_b1;

  always @(posedge clk_pixel) cyc <= cyc + 1;

  always @(negedge clk_pixel) begin
    if (v0) begin
      q0.push_back({r0, g0, b0, x0, y0, sof0, eol0});
      if (first0 < 0) first0 = cyc;
    end
    if (v1) begin
      q1.push_back({r1, g1, b1, x1, y1, sof1, eol1});
      if (first1 < 0) first1 = cyc;
    end
    if (eof0) n_eof0++;
    if (eof1) n_eof1++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic send_line(input int n, input logic [7:0] p0, input logic [7:0] p1);
    for (int i = 0; i < n; i++) begin
      cam_href = 1'b1;
      cam_data = (i % 2 == 1) ? p1 : p0;
      if (i == 1 && t_b1 < 0) t_b1 = cyc;
      tick();
    end
    cam_href = 1'b0;
    cam_data = 8'h00;
    repeat (4) tick();
  endtask

  // One frame: vsync fall, two lines, vsync rise. mode and capture_en are
  // disturbed after the frame start to show they are only sampled there.
  task automatic frame(input logic [1:0] m, input logic en, input int n0, input int n1,
                       input logic [7:0] p0, input logic [7:0] p1);
    q0.delete(); q1.delete();
    n_eof0 = 0; n_eof1 = 0; first0 = -1; first1 = -1; t_b1 = -1;
    mode = m; capture_en = en; cam_vsync = 1'b0;
    repeat (4) tick();
    capture_en = 1'b1;
    mode = m ^ 2'd3;
    send_line(n0, p0, p1);
    send_line(n1, p0, p1);
    cam_vsync = 1'b1;
    repeat (5) tick();
  endtask

  task automatic check_first(input string tag, input logic [7:0] er, input logic [7:0] eg,
                             input logic [7:0] eb);
    check({tag, "_count"}, q0.size(), 8);
    if (q0.size() > 0) begin
      check({tag, "_r"}, q0[0].r, er);
      check({tag, "_g"}, q0[0].g, eg);
      check({tag, "_b"}, q0[0].b, eb);
    end
  endtask

  initial begin
    int neol;
    rst_n = 1'b0; cam_vsync = 1'b1; cam_href = 1'b0; cam_data = 8'h00;
    capture_en = 1'b1; mode = 2'd0;
    n_eof0 = 0; n_eof1 = 0; first0 = -1; first1 = -1; t_b1 = -1;
    repeat (3) tick();
    check("rst_valid", v0, 0);
    check("rst_cnt", cnt0, 0);
    check("rst_err", err0, 0);
    check("rst_eof", eof0, 0);
    check("rst_sof", sof0, 0);
    check("rst_x", x0, 0);
    rst_n = 1'b1;
    repeat (4) tick();

    // RGB565 red frame, full coordinate/marker check.
    frame(2'd0, 1'b1, 8, 8, 8'hF8, 8'h00);
    check("t1_count", q0.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < q0.size()) begin
        check($sformatf("t1_r%0d", i), q0[i].r, 8'hFF);
        check($sformatf("t1_g%0d", i), q0[i].g, 8'h00);
        check($sformatf("t1_b%0d", i), q0[i].b, 8'h00);
        check($sformatf("t1_x%0d", i), q0[i].x, i % 4);
        check($sformatf("t1_y%0d", i), q0[i].y, i / 4);
        check($sformatf("t1_sof%0d", i), q0[i].sof, (i == 0) ? 1 : 0);
        check($sformatf("t1_eol%0d", i), q0[i].eol, (i % 4 == 3) ? 1 : 0);
      end
    end
    check("t1_eof", n_eof0, 1);
    check("t1_cnt", cnt0, 1);
    check("t1_err", err0, 0);

    frame(2'd1, 1'b1, 8, 8, 8'h0A, 8'h5F);
    check_first("rgb444", 8'hAA, 8'h55, 8'hFF);
    check("rgb444_cnt", cnt0, 2);

    frame(2'd3, 1'b1, 8, 8, 8'h80, 8'h12);
    check_first("yuyv", 8'h80, 8'h80, 8'h80);
    check("yuyv_cnt1", cnt1, 3);

    frame(2'd2, 1'b1, 8, 8, 8'h7C, 8'h00);
    check_first("rgb555", 8'hFF, 8'h00, 8'h00);
    check("wrap_cnt1", cnt1, 0);
    check("wrap_cnt0", cnt0, 4);

    // Swapped bytes: dut1 sees F8,00 after swap, dut0 decodes 00,F8 directly.
    frame(2'd0, 1'b1, 8, 8, 8'h00, 8'hF8);
    check("swap_count", q1.size(), 8);
    if (q1.size() > 0) begin
      check("swap_r1", q1[0].r, 8'hFF);
      check("swap_g1", q1[0].g, 8'h00);
    end
    check_first("noswap", 8'h00, 8'h1C, 8'hC6);
    check("lat_dut1", first1, t_b1 + 2);
    check("lat_dut0", first0, t_b1 + 2);
    check("swap_cnt1", cnt1, 1);

    // Short first line (7 bytes): 3 pixels, dangling byte, error.
    frame(2'd0, 1'b1, 7, 8, 8'hF8, 8'h00);
    check("short_count", q0.size(), 7);
    neol = 0;
    foreach (q0[i]) if (q0[i].eol) neol++;
    check("short_eol", neol, 1);
    if (q0.size() > 3) begin
      check("short_p3_x", q0[3].x, 0);
      check("short_p3_y", q0[3].y, 1);
    end
    check("short_err", err0, 1);
    frame(2'd0, 1'b1, 8, 8, 8'hF8, 8'h00);
    check("err_cleared", err0, 0);
    check("clean_cnt", cnt0, 7);

    // Skipped frame, capture enabled only mid-frame.
    frame(2'd0, 1'b0, 8, 8, 8'hF8, 8'h00);
    check("skip_pix", q0.size(), 0);
    check("skip_eof", n_eof0, 0);
    check("skip_cnt", cnt0, 7);
    frame(2'd0, 1'b1, 8, 8, 8'hF8, 8'h00);
    check("after_skip", q0.size(), 8);
    check("after_skip_cnt", cnt0, 8);

    // Reset in the middle of a line with vsync low.
    mode = 2'd0; capture_en = 1'b1; cam_vsync = 1'b0;
    repeat (4) tick();
    cam_href = 1'b1; cam_data = 8'hF8;
    tick();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    q0.delete(); q1.delete(); n_eof0 = 0;
    for (int i = 1; i < 8; i++) begin
      cam_data = (i % 2 == 1) ? 8'h00 : 8'hF8;
      tick();
    end
    cam_href = 1'b0;
    repeat (4) tick();
    send_line(8, 8'hF8, 8'h00);
    cam_vsync = 1'b1;
    repeat (5) tick();
    check("rstmid_pix0", q0.size(), 0);
    check("rstmid_pix1", q1.size(), 0);
    check("rstmid_eof", n_eof0, 0);
    check("rstmid_cnt", cnt0, 0);
    frame(2'd0, 1'b1, 8, 8, 8'hF8, 8'h00);
    check("post_rst_count", q0.size(), 8);
    if (q0.size() > 0) begin
      check("post_rst_sof", q0[0].sof, 1);
      check("post_rst_x", q0[0].x, 0);
      check("post_rst_y", q0[0].y, 0);
    end
    check("post_rst_cnt", cnt0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
